relprime_engine: RTL

- Parametrised hardware relprime unit. For input n, returns the smallest m >= START_M with gcd(n, m) = 1.
- GCD is computed by subtraction-based Euclid, one subtract per clock.
- Supersedes the fixed 16-bit, software-driven relprime datapath. Adds a start/busy/done handshake, width and start-candidate parameters, error reporting, and async reset.
- Sits beside the processor top level as a memory-mapped-style accelerator.

---
 rtl/relprime_engine.sv | 137 +++++++++++++
 1 files changed

// File: rtl/relprime_engine.sv
// relprime_engine: for operand n, finds the smallest m >= START_M with gcd(n, m) == 1.
// Latency: one cycle per subtractive-Euclid step, plus one CHECK cycle per candidate, plus one DONE cycle.
// Backpressure: none. A start seen while busy is dropped, and the result is held until the next accepted start.
//
// Ports:
//   CLK, RST_N       clock and async active-low reset (sync release)
//   start, n_in      request; n_in is captured on an accepted start (IDLE only)
//   busy             high in every state except IDLE
//   done             one-cycle pulse in the DONE state
//   error            valid with done; set when no coprime candidate exists (n==0 or candidate wrap)
//   result           smallest coprime m, or 0 on error
//   cycle_count      (only with RELPRIME_CYCLE_COUNT_EN) saturating count of GCD+CHECK cycles
//
// Optional feature macro: RELPRIME_CYCLE_COUNT_EN
module relprime_engine #(
  parameter int WIDTH   = 16,
  parameter int START_M = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
`ifdef RELPRIME_CYCLE_COUNT_EN
  ,
  output logic [WIDTH-1:0] cycle_count
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GCD   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] M_FIRST = WIDTH'(START_M);
  localparam logic [WIDTH-1:0] M_LAST  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m_next;

  assign m_next = m + ONE;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      n_reg  <= '0;
      m      <= '0;
      a      <= '0;
      b      <= '0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Any accepted start clears the old outcome.
            result <= '0;
            if (n_in == '0) begin
              // gcd(0, m) == m, which is never 1 for m >= 2.
              error <= 1'b1;
              state <= S_DONE;
            end else begin
              error <= 1'b0;
              n_reg <= n_in;
              m     <= M_FIRST;
              a     <= n_in;
              b     <= M_FIRST;
              state <= S_GCD;
            end
          end
        end

        S_GCD: begin
          // The larger operand is always the minuend, so nothing underflows.
          // a never reaches 0 because it only shrinks while strictly larger than b.
          if (b == '0) begin
            state <= S_CHECK;
          end else if (a > b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end

        S_CHECK: begin
          if (a == ONE) begin
            result <= m;
            error  <= 1'b0;
            state  <= S_DONE;
          end else if (m == M_LAST) begin
            // The next candidate would wrap to 0, so give up.
            result <= '0;
            error  <= 1'b1;
            state  <= S_DONE;
          end else begin
            m     <= m_next;
            a     <= n_reg;
            b     <= m_next;
            state <= S_GCD;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RELPRIME_CYCLE_COUNT_EN
  // Counts only GCD and CHECK cycles, so the count stays frozen in DONE and IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycle_count <= '0;
    end else if (state == S_IDLE && start) begin
      cycle_count <= '0;
    end else if ((state == S_GCD || state == S_CHECK) && cycle_count != M_LAST) begin
      cycle_count <= cycle_count + ONE;
    end
  end
`endif

endmodule
